approx_adder_seq: RTL and testbench



---
 rtl/approx_adder_seq_if.sv | 26 ++
 rtl/approx_adder_seq.sv | 158 +++++++++++++++
 tb/tb_approx_adder_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/approx_adder_seq_if.sv
// Request/response handshake bundle for approx_adder_seq.
// The master side issues operand requests and accepts results; the slave side is the sequencer.
interface approx_adder_seq_if #(
  parameter int N  = 16,
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic [AW-1:0] in_acc;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic          out_cout;

  modport master (
    output in_valid, in_a, in_b, in_acc, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_acc, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/approx_adder_seq.sv
// Multi-cycle sequencer driving a W-bit slice of maskable approximate adder cells over N-bit operands.
// Optional error statistics (exact-sum comparison, err_flag, err_cnt) are enabled by APPROX_ERR_STAT_EN.
module approx_adder_seq #(
  parameter int N  = 16,
  parameter int W  = 4,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  approx_adder_seq_if.slave    bus,
  output logic                 busy
`ifdef APPROX_ERR_STAT_EN
  ,
  output logic                 err_flag,
  output logic [15:0]          err_cnt
`endif
);

  localparam int NCHUNK = N / W;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  logic [N-1:0]  a_q, b_q, mask_q;
  logic [N-1:0]  mask_d;
  logic [AW-1:0] acc_c;
  logic [W-1:0]  chunk_sum;
  logic          chunk_cout;
  logic          accept;

  assign accept        = bus.in_valid && (state_q == IDLE);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign busy          = (state_q != IDLE);

  // Thermometer mask: the top acc bits are accurate, oversized requests clamp to N.
  always_comb begin
    acc_c  = bus.in_acc;
    mask_d = '0;
    if (int'(bus.in_acc) > N) acc_c = AW'(N);
    for (int i = 0; i < N; i++) begin
      mask_d[i] = ((i + int'(acc_c)) >= N);
    end
  end

  // Cell slice: operands are shifted down each RUN cycle, so the current chunk is always bits [W-1:0].
  // NOTE: blocking assignments here chain the carry bit-to-bit within one evaluation; the
  // always_ff blocks below use non-blocking so every register samples pre-edge values.
  always_comb begin
    logic c;
    logic g, p;
    c         = carry_q;
    chunk_sum = '0;
    for (int i = 0; i < W; i++) begin
      g = a_q[i] & b_q[i] & mask_q[i];
      p = (a_q[i] ^ b_q[i]) & mask_q[i];
      chunk_sum[i] = mask_q[i] ? (a_q[i] ^ b_q[i] ^ c) : (a_q[i] | b_q[i]);
      c            = g | (p & c);
    end
    chunk_cout = c;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d             = sum_q >> W;
        sum_d[N-1 -: W]   = chunk_sum;
        carry_d           = chunk_cout;
        if (cnt_q == LAST) begin
          cout_d  = chunk_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // NOTE: operand and mask registers are always loaded on acceptance before they are read,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= bus.in_a;
      b_q    <= bus.in_b;
      mask_q <= mask_d;
    end else if (state_q == RUN) begin
      a_q    <= a_q >> W;
      b_q    <= b_q >> W;
      mask_q <= mask_q >> W;
    end
  end

`ifdef APPROX_ERR_STAT_EN
  logic [N:0]  exact_q;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk) begin
    if (accept) exact_q <= {1'b0, bus.in_a} + {1'b0, bus.in_b};
  end

  assign err_flag = (state_q == DONE) && ({cout_q, sum_q} != exact_q);
  assign err_cnt  = err_cnt_q;

  // Count erroneous results at their output handshake, saturating at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_flag && bus.out_ready && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end
`endif

endmodule

// File: tb/tb_approx_adder_seq.sv
// Scoreboard bench for approx_adder_seq: stimulus pushes hand-computed results, a monitor pops
// and compares at each output handshake. Error-statistics checks follow APPROX_ERR_STAT_EN.
module tb_approx_adder_seq;

  localparam int N  = 16;
  localparam int W  = 4;
  localparam int AW = 5;

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         err;
    int           acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
`ifdef APPROX_ERR_STAT_EN
  logic        err_flag;
  logic [15:0] err_cnt;
`endif

  approx_adder_seq_if #(.N(N), .AW(AW)) bus ();

  approx_adder_seq #(.N(N), .W(W), .AW(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
`ifdef APPROX_ERR_STAT_EN
    ,
    .err_flag (err_flag),
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   exp_err_cnt = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: latency on the rising edge of out_valid, payload at each handshake.
  always @(negedge clk) begin
    if (bus.out_valid && !prev_valid) begin
      if (sb.size() == 0) check("spurious_valid", 64'(bus.out_valid), 64'd0);
      else                check("latency", 64'(cyc - sb[0].acc_cyc), 64'd4);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'(bus.out_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_sum", 64'(bus.out_sum), 64'(e.sum));
        check("out_cout", 64'(bus.out_cout), 64'(e.cout));
`ifdef APPROX_ERR_STAT_EN
        check("err_flag", 64'(err_flag), 64'(e.err));
        check("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
        if (e.err) exp_err_cnt++;
`endif
      end
    end
    prev_valid = bus.out_valid;
  end

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) return;
    end
    check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
  endtask

  // Issue one request; if push is set, its hand-computed result goes to the scoreboard.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [AW-1:0] acc,
                      input logic [N-1:0] s, input logic co, input logic er, input bit push);
    exp_t e;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_acc   = acc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    e.sum = s; e.cout = co; e.err = er; e.acc_cyc = cyc;
    if (push) sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_sum"},   64'(bus.out_sum),   64'd0);
    check({tag, "_out_cout"},  64'(bus.out_cout),  64'd0);
    check({tag, "_busy"},      64'(busy),          64'd0);
`ifdef APPROX_ERR_STAT_EN
    check({tag, "_err_cnt"},   64'(err_cnt),       64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_acc    = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    //    a         b         acc     sum       cout  err
    send(16'h00FF, 16'h0001, 5'd16, 16'h0100, 1'b0, 1'b0, 1'b1);
    send(16'h00FF, 16'h0001, 5'd8,  16'h00FF, 1'b0, 1'b1, 1'b1);
    send(16'hFFFF, 16'h0001, 5'd16, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0001, 5'd0,  16'hFFFF, 1'b0, 1'b1, 1'b1);
    send(16'h1234, 16'h1111, 5'd31, 16'h2345, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 5'd4,  16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h0F0F, 16'h0101, 5'd12, 16'h100F, 1'b0, 1'b1, 1'b1);
    send(16'h8001, 16'h8001, 5'd1,  16'h0001, 1'b1, 1'b1, 1'b1);

    // Backpressure: DONE holds with frozen outputs and ignores a new request.
    wait_ready();
    bus.out_ready = 1'b0;
    send(16'h00FF, 16'h0001, 5'd16, 16'h0100, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    check("done_reached", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'hAAAA;
    bus.in_b     = 16'h5555;
    bus.in_acc   = 5'd16;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid",    64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready),  64'd0);
      check("hold_sum",      64'(bus.out_sum),   64'h0100);
      check("hold_cout",     64'(bus.out_cout),  64'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", 64'(bus.in_ready),  64'd1);
    check("release_valid",    64'(bus.out_valid), 64'd0);
    send(16'hFFFF, 16'h0001, 5'd16, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Reset during the second RUN cycle aborts the request without a result.
    send(16'h00FF, 16'h0001, 5'd8, 16'h00FF, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err_cnt = 0;
    @(negedge clk);
    check_reset_outputs("abort");
    repeat (8) @(negedge clk);
    check("abort_no_valid", 64'(bus.out_valid), 64'd0);
    send(16'h0F0F, 16'h0101, 5'd12, 16'h100F, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
